// File: rtl/mult_8x8_rr_sched_if.sv
// Requester-side bundle for the shared 8x8 multiplier: issue handshake plus
// per-requester result slots.
interface mult_8x8_rr_sched_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [8*NUM_REQ-1:0]  req_a;
  logic [8*NUM_REQ-1:0]  req_b;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [NUM_REQ-1:0]    rsp_ack;
  logic [16*NUM_REQ-1:0] rsp_product;

  modport master (
    output req_valid, req_a, req_b, rsp_ack,
    input  req_ready, rsp_valid, rsp_product
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ack,
    output req_ready, rsp_valid, rsp_product
  );
endinterface

// File: rtl/mult_8x8_rr_sched.sv
// Round-robin scheduler sharing one pipelined 8x8 unsigned multiplier among
// NUM_REQ requesters, each owning a single result slot.
module mult_8x8_rr_sched #(
  parameter int NUM_REQ  = 4,
  parameter int MULT_LAT = 2
) (
  input  logic               clk,
  input  logic               rst,
  mult_8x8_rr_sched_if.slave bus,
  output logic               busy
);
  localparam int DATA_W = 8;
  localparam int PROD_W = 2 * DATA_W;
  localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  function automatic logic [PROD_W-1:0] umul(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
    return PROD_W'(a) * PROD_W'(b);
  endfunction

  function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base,
                                                input int               ofs);
    int s;
    s = int'(base) + ofs;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return PTR_W'(s);
  endfunction

  logic [NUM_REQ-1:0]        pending;
  logic [NUM_REQ-1:0]        rsp_valid_q;
  logic [PROD_W*NUM_REQ-1:0] rsp_prod_q;
  logic [NUM_REQ-1:0]        eligible;
  logic [NUM_REQ-1:0]        grant;
  logic [NUM_REQ-1:0]        done_vec;
  logic [PTR_W-1:0]          rr_ptr;
  logic [PTR_W-1:0]          gidx;
  logic [PTR_W-1:0]          ptr_nxt;
  logic                      any_grant;

  logic [MULT_LAT-1:0]       vld_p;
  logic [PTR_W-1:0]          tag_p [MULT_LAT];
  logic [DATA_W-1:0]         a_p0;
  logic [DATA_W-1:0]         b_p0;
  logic [PROD_W-1:0]         mul_p0;
  logic [PROD_W-1:0]         prod_done;

  // A requester with an op in flight or an unread result may not issue again,
  // which is what lets the pipeline run without stalls.
  always_comb begin
    eligible = bus.req_valid & ~pending & ~rsp_valid_q;
  end

  always_comb begin
    grant     = '0;
    gidx      = '0;
    any_grant = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!any_grant && eligible[wrap_idx(rr_ptr, k)]) begin
        any_grant                  = 1'b1;
        gidx                       = wrap_idx(rr_ptr, k);
        grant[wrap_idx(rr_ptr, k)] = 1'b1;
      end
    end
  end

  assign ptr_nxt = (gidx == PTR_W'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;

  always_comb begin
    done_vec = '0;
    if (vld_p[MULT_LAT-1]) done_vec[tag_p[MULT_LAT-1]] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr      <= '0;
      pending     <= '0;
      rsp_valid_q <= '0;
      vld_p       <= '0;
    end else begin
      if (any_grant) rr_ptr <= ptr_nxt;
      pending     <= (pending | grant) & ~done_vec;
      rsp_valid_q <= (rsp_valid_q & ~bus.rsp_ack) | done_vec;
      vld_p       <= MULT_LAT'({vld_p, any_grant});
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_prod_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (done_vec[i]) rsp_prod_q[PROD_W*i +: PROD_W] <= prod_done;
      end
    end
  end

  // Stage 0: capture operands and tag of the granted requester
  always_ff @(posedge clk) begin
    if (any_grant) begin
      a_p0 <= bus.req_a[int'(gidx)*DATA_W +: DATA_W];
      b_p0 <= bus.req_b[int'(gidx)*DATA_W +: DATA_W];
    end
    tag_p[0] <= gidx;
    for (int s = 1; s < MULT_LAT; s++) tag_p[s] <= tag_p[s-1];
  end

  assign mul_p0 = umul(a_p0, b_p0);

  // Stages 1..MULT_LAT-1: carry the product to the completion point
  if (MULT_LAT == 1) begin : g_lat1
    assign prod_done = mul_p0;
  end else begin : g_latn
    logic [PROD_W-1:0] prod_p [1:MULT_LAT-1];
    always_ff @(posedge clk) begin
      prod_p[1] <= mul_p0;
      for (int s = 2; s < MULT_LAT; s++) prod_p[s] <= prod_p[s-1];
    end
    assign prod_done = prod_p[MULT_LAT-1];
  end

  assign bus.req_ready   = grant;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_product = rsp_prod_q;
  assign busy            = |vld_p;
endmodule

// File: tb/tb_mult_8x8_rr_sched.sv
// Bench for mult_8x8_rr_sched: a 4-requester/2-stage build and a
// 2-requester/1-stage build driven from one clock.
module tb_mult_8x8_rr_sched;
  logic clk = 1'b0;
  logic rst;
  logic busy_a, busy_b;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  mult_8x8_rr_sched_if #(.NUM_REQ(4)) ia ();
  mult_8x8_rr_sched_if #(.NUM_REQ(2)) ib ();

  mult_8x8_rr_sched #(.NUM_REQ(4), .MULT_LAT(2)) dut_a (
    .clk(clk), .rst(rst), .bus(ia), .busy(busy_a));
  mult_8x8_rr_sched #(.NUM_REQ(2), .MULT_LAT(1)) dut_b (
    .clk(clk), .rst(rst), .bus(ib), .busy(busy_b));

  typedef struct { logic [7:0] a; logic [7:0] b; logic [15:0] p; } vec_t;
  typedef struct { int tag; logic [15:0] prod; int due; } flight_t;

  vec_t        vt [6];
  flight_t     fq [$];
  int          grants [$];
  int          exp_hold [13];
  logic [3:0]  m_rv, m_pend, elig, rdy;
  logic [15:0] m_prod [4];
  int          m_ptr, ops, cyc, g, idx, regrant2;
  logic        seen2;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] prod_a(input int i);
    return ia.rsp_product[16*i +: 16];
  endfunction

  function automatic logic [15:0] prod_b(input int i);
    return ib.rsp_product[16*i +: 16];
  endfunction

  function automatic logic [7:0] pick();
    case ($urandom_range(0, 7))
      0:       return 8'h00;
      1:       return 8'hFF;
      2:       return 8'h01;
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    ia.req_valid = '0; ia.rsp_ack = '0; ia.req_a = '0; ia.req_b = '0;
    ib.req_valid = '0; ib.rsp_ack = '0; ib.req_a = '0; ib.req_b = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic single_a(input int r, input vec_t v);
    @(negedge clk);
    ia.req_valid = 4'(1 << r);
    ia.req_a[8*r +: 8] = v.a;
    ia.req_b[8*r +: 8] = v.b;
    #1 chk("single_ready", 64'(ia.req_ready), 64'(1 << r));
    @(negedge clk);
    chk("single_busy_c1", 64'(busy_a), 64'(1));
    chk("single_rv_c1", 64'(ia.rsp_valid), 64'(0));
    ia.req_valid = '0;
    @(negedge clk);
    chk("single_busy_c2", 64'(busy_a), 64'(1));
    chk("single_rv_c2", 64'(ia.rsp_valid), 64'(0));
    @(negedge clk);
    chk("single_rv_done", 64'(ia.rsp_valid), 64'(1 << r));
    chk("single_product", 64'(prod_a(r)), 64'(v.p));
    chk("single_busy_idle", 64'(busy_a), 64'(0));
    ia.rsp_ack = 4'(1 << r);
    @(negedge clk);
    chk("single_rv_acked", 64'(ia.rsp_valid), 64'(0));
    chk("single_product_held", 64'(prod_a(r)), 64'(v.p));
    ia.rsp_ack = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{8'hFF, 8'hFF, 16'hFE01};
    vt[1] = '{8'h00, 8'hAB, 16'h0000};
    vt[2] = '{8'h01, 8'hFF, 16'h00FF};
    vt[3] = '{8'h0F, 8'h11, 16'h00FF};
    vt[4] = '{8'h80, 8'h80, 16'h4000};
    vt[5] = '{8'hFF, 8'h02, 16'h01FE};
    exp_hold = '{0, 1, 2, 3, 0, 1, 3, 0, 1, 3, 0, 1, 3};

    do_reset();
    @(negedge clk);
    chk("reset_rsp_valid_a", 64'(ia.rsp_valid), 64'(0));
    chk("reset_product_a", 64'(ia.rsp_product), 64'(0));
    chk("reset_busy_a", 64'(busy_a), 64'(0));
    chk("reset_ready_a", 64'(ia.req_ready), 64'(0));
    chk("reset_rsp_valid_b", 64'(ib.rsp_valid), 64'(0));
    chk("reset_busy_b", 64'(busy_b), 64'(0));

    for (int i = 0; i < 6; i++) single_a(i % 4, vt[i]);

    // fairness: everyone always requesting, results consumed immediately
    do_reset();
    for (int i = 0; i < 4; i++) begin
      ia.req_a[8*i +: 8] = 8'(i + 1);
      ia.req_b[8*i +: 8] = 8'h10;
    end
    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++)
        if (ia.rsp_valid[i]) chk("fair_product", 64'(prod_a(i)), 64'((i + 1) * 16));
      ia.rsp_ack   = ia.rsp_valid;
      ia.req_valid = '1;
      #1 chk("fair_grant", 64'(ia.req_ready), 64'(1 << (n % 4)));
    end

    // hold-off: requester 2 never consumes its result
    do_reset();
    for (int i = 0; i < 4; i++) begin
      ia.req_a[8*i +: 8] = (i == 2) ? 8'h80 : 8'(i + 3);
      ia.req_b[8*i +: 8] = (i == 2) ? 8'h80 : 8'h07;
    end
    grants.delete();
    seen2 = 1'b0;
    regrant2 = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      ia.rsp_ack   = ia.rsp_valid & 4'b1011;
      ia.req_valid = '1;
      #1 rdy = ia.req_ready;
      if ($countones(rdy) > 1) chk("hold_onehot", 64'(rdy), 64'(0));
      if (seen2 && rdy[2]) regrant2++;
      if (rdy[2]) seen2 = 1'b1;
      for (int i = 0; i < 4; i++) if (rdy[i]) grants.push_back(i);
    end
    chk("hold_grant_count_ok", 64'(grants.size() >= 13), 64'(1));
    for (int i = 0; i < 13 && i < grants.size(); i++)
      chk("hold_order", 64'(grants[i]), 64'(exp_hold[i]));
    chk("hold_no_regrant", 64'(regrant2), 64'(0));
    chk("hold_rv2", 64'(ia.rsp_valid[2]), 64'(1));
    chk("hold_product2", 64'(prod_a(2)), 64'(16'h4000));

    // asynchronous reset with two operations in flight
    do_reset();
    ia.req_a = 32'h0505_0303; ia.req_b = 32'h0606_0404;
    @(negedge clk);
    ia.req_valid = 4'b1010;
    #1 chk("rst_ready_first", 64'(ia.req_ready), 64'(4'b0010));
    @(negedge clk);
    chk("rst_ready_second", 64'(ia.req_ready), 64'(4'b1000));
    chk("rst_busy_before", 64'(busy_a), 64'(1));
    @(posedge clk);
    #2 ia.req_valid = '0;
    rst = 1'b1;
    #1;
    chk("rst_async_rv", 64'(ia.rsp_valid), 64'(0));
    chk("rst_async_busy", 64'(busy_a), 64'(0));
    chk("rst_async_product", 64'(ia.rsp_product), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      chk("rst_no_late_rv", 64'(ia.rsp_valid), 64'(0));
      chk("rst_no_late_busy", 64'(busy_a), 64'(0));
    end
    ia.req_valid = 4'b1010;
    #1 chk("rst_first_grant", 64'(ia.req_ready), 64'(4'b0010));
    ia.req_valid = '0;

    // single-stage, two-requester build
    do_reset();
    @(negedge clk);
    ib.req_valid = 2'b01; ib.req_a[7:0] = 8'h12; ib.req_b[7:0] = 8'h34; ib.rsp_ack = 2'b01;
    #1 chk("b_ready_0", 64'(ib.req_ready), 64'(2'b01));
    @(negedge clk);
    chk("b_rv_issue", 64'(ib.rsp_valid), 64'(0));
    chk("b_busy_1", 64'(busy_b), 64'(1));
    ib.req_valid = 2'b10; ib.req_a[15:8] = 8'hFE; ib.req_b[15:8] = 8'h03;
    #1 chk("b_ready_1", 64'(ib.req_ready), 64'(2'b10));
    @(negedge clk);
    chk("b_rv_0_done", 64'(ib.rsp_valid), 64'(2'b01));
    chk("b_product_0", 64'(prod_b(0)), 64'(16'h03A8));
    chk("b_busy_2", 64'(busy_b), 64'(1));
    ib.req_valid = 2'b01; ib.req_a[7:0] = 8'h07; ib.req_b[7:0] = 8'h09; ib.rsp_ack = 2'b01;
    #1 chk("b_ready_blocked", 64'(ib.req_ready), 64'(0));
    @(negedge clk);
    chk("b_rv_1_done", 64'(ib.rsp_valid), 64'(2'b10));
    chk("b_product_1", 64'(prod_b(1)), 64'(16'h02FA));
    chk("b_product_0_held", 64'(prod_b(0)), 64'(16'h03A8));
    chk("b_busy_idle", 64'(busy_b), 64'(0));
    ib.rsp_ack = 2'b10;
    #1 chk("b_ready_reissue", 64'(ib.req_ready), 64'(2'b01));
    @(negedge clk);
    chk("b_rv_cleared", 64'(ib.rsp_valid), 64'(0));
    chk("b_busy_3", 64'(busy_b), 64'(1));
    ib.req_valid = '0; ib.rsp_ack = '0;
    @(negedge clk);
    chk("b_rv_0_again", 64'(ib.rsp_valid), 64'(2'b01));
    chk("b_product_0_new", 64'(prod_b(0)), 64'(16'h003F));

    // randomized traffic against a per-requester model
    do_reset();
    m_rv = '0; m_pend = '0; m_ptr = 0; ops = 0; cyc = 0;
    for (int i = 0; i < 4; i++) m_prod[i] = '0;
    fq.delete();
    while (ops < 1000 && cyc < 8000) begin
      @(negedge clk);
      chk("rnd_rsp_valid", 64'(ia.rsp_valid), 64'(m_rv));
      for (int i = 0; i < 4; i++)
        if (m_rv[i]) chk("rnd_product", 64'(prod_a(i)), 64'(m_prod[i]));
      chk("rnd_busy", 64'(busy_a), 64'(fq.size() != 0));
      for (int i = 0; i < 4; i++) begin
        ia.req_valid[i]    = ($urandom_range(0, 3) != 0);
        ia.rsp_ack[i]      = 1'($urandom_range(0, 1));
        ia.req_a[8*i +: 8] = pick();
        ia.req_b[8*i +: 8] = pick();
      end
      #1;
      elig = ia.req_valid & ~m_pend & ~m_rv;
      g = -1;
      for (int k = 0; k < 4; k++) begin
        idx = (m_ptr + k) % 4;
        if (g < 0 && elig[idx]) g = idx;
      end
      chk("rnd_ready", 64'(ia.req_ready), (g >= 0) ? 64'(1 << g) : 64'(0));
      m_rv = m_rv & ~ia.rsp_ack;
      while (fq.size() > 0 && fq[0].due == cyc) begin
        m_rv[fq[0].tag]   = 1'b1;
        m_prod[fq[0].tag] = fq[0].prod;
        m_pend[fq[0].tag] = 1'b0;
        void'(fq.pop_front());
      end
      if (g >= 0) begin
        fq.push_back('{g, 16'(int'(ia.req_a[8*g +: 8]) * int'(ia.req_b[8*g +: 8])), cyc + 2});
        m_pend[g] = 1'b1;
        m_ptr = (g + 1) % 4;
        ops++;
      end
      cyc++;
    end
    chk("rnd_op_count_reached", 64'(ops >= 1000), 64'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mult_8x8_rr_sched.md
Name: mult_8x8_rr_sched

Overview:
- Round-robin scheduler that shares one pipelined 8x8 unsigned multiplier among NUM_REQ requesters.
- Each requester issues one operation, then collects its 16-bit product from a dedicated result slot.
- Sits between several DSP/control clients and the single multiplier instance, replacing per-client multipliers.
- At most one issue per cycle; fully pipelined, so throughput is one product per cycle.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- MULT_LAT, 2: multiplier pipeline depth in cycles (>=1); equals issue-to-result latency.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester operation request.
- req_ready  output  NUM_REQ  one-hot grant; handshake when req_valid[i] & req_ready[i].
- req_a  input  8*NUM_REQ  operand a of requester i at bits [8i+7:8i].
- req_b  input  8*NUM_REQ  operand b of requester i at bits [8i+7:8i].
- rsp_valid  output  NUM_REQ  result slot i holds an unconsumed product.
- rsp_ack  input  NUM_REQ  consume result slot i.
- rsp_product  output  16*NUM_REQ  product of requester i at bits [16i+15:16i].
- busy  output  1  any pipeline stage holds a valid operation.

Behaviour:
- Reset values, asynchronous on rst=1:
  - rsp_valid=0 and rsp_product=0.
  - pending=0, all pipeline valid bits=0, rr_ptr=0, busy=0.
  - In-flight operations are discarded, with no response.
- Eligibility: eligible[i] = req_valid[i] & ~pending[i] & ~rsp_valid[i].
  - pending and rsp_valid are registered state.
  - req_ready depends combinationally on req_valid only.
  - Requesters must not make req_valid depend on req_ready.
- Arbitration: grant the first eligible index searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - req_ready is one-hot or zero.
  - On a grant to index g: rr_ptr <= (g+1) mod NUM_REQ. With no grant, rr_ptr holds.
- Issue, on a handshake for requester g at edge k:
  - Stage 0 captures a, b, tag g, and valid=1.
  - pending[g] <= 1.
  - Operands must be stable only during the handshake cycle.
- Pipeline:
  - MULT_LAT register stages carry {valid, tag, partial/final product}.
  - Product = a*b as unsigned, zero-extended to 16 bits; no truncation (max 255*255 = 0xFE01).
  - The stages never stall; backpressure is prevented by the eligibility rule.
- Completion: at edge k+MULT_LAT, for tag t:
  - rsp_product[t] <= product, rsp_valid[t] <= 1, pending[t] <= 0.
  - rsp_valid[t] is high during cycle k+MULT_LAT.
- Consumption: rsp_ack[i] while rsp_valid[i]=1 clears rsp_valid[i] at the next edge.
  - rsp_product[i] holds its last value.
  - rsp_ack[i] while rsp_valid[i]=0 is ignored.
- Re-issue: requester i becomes eligible in the cycle after its ack edge.
  - Minimum per-requester period is MULT_LAT+2 cycles.
  - Aggregate throughput reaches 1 op/cycle when NUM_REQ >= MULT_LAT+2.
- Simultaneous events:
  - A completion and an ack for the same index cannot coincide, because rsp_valid=0 while pending.
  - Completion for index i and a grant to index j in the same cycle are independent.
  - A requester dropping req_valid before its handshake is legal; no state change results.
- busy = OR of pipeline stage valid bits. It does not reflect unconsumed rsp_valid slots.
- Wrap-around: when rr_ptr=NUM_REQ-1 and that requester is granted, rr_ptr returns to 0.

Test Plan:
- Single request: MULT_LAT=2, req 0 with a=0xFF, b=0xFF handshake at edge 0 -> rsp_valid[0]=1 after edge 2, rsp_product[0]=0xFE01, busy high for 2 cycles.
- Fairness: all 4 requesters hold req_valid=1 and ack immediately -> grant order 0,1,2,3,0,1,...; no index granted twice before the others; one grant per cycle when eligible.
- Hold-off: requester 2 never acks (a=0x80, b=0x80) -> rsp_valid[2] stays 1, rsp_product[2]=0x4000, req_ready[2] never reasserts; others continue rotating 0,1,3.
- Edge operands: a=0, b=0xAB -> 0x0000; a=1, b=0xFF -> 0x00FF; a=0x0F, b=0x11 -> 0x00FF; checked against an a*b model over 1000 random ops.
- Reset mid-operation: rst pulsed asynchronously with two ops in flight -> all rsp_valid=0, busy=0, no late responses appear; after release the first grant goes to the lowest eligible index starting from 0.
- MULT_LAT=1 and NUM_REQ=2 build: back-to-back alternating grants 0,1,0 -> each result valid one edge after its handshake; an ack with rsp_valid=0 has no effect.
